// File: rtl/multi_cycle_adder_pkg.sv
// Shared types and sizing helpers for multi_cycle_adder.
package multi_cycle_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic int chunk_count(input int n, input int w);
        return n / w;
    endfunction

    // A lone chunk still needs a one-bit index so the counter never collapses to zero width.
    function automatic int index_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain N-bit ripple-carry adder used as the narrow chunk adder.
module ripple_carry_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] sum,
    output logic         co
);

    logic carry;

    always_comb begin
        carry = ci;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/multi_cycle_adder.sv
// N-bit adder built from one W-bit chunk adder, LS chunk first, result on valid/ready.
// Optional signed-overflow output enabled by defining MULTI_CYCLE_ADDER_OVF_EN.
module multi_cycle_adder
    import multi_cycle_adder_pkg::*;
#(
    parameter int N = 64,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout
`ifdef MULTI_CYCLE_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int K  = chunk_count(N, W);
    localparam int IW = index_width(K);

    generate
        if (N % W != 0) begin : g_bad_chunk_width
            $error("multi_cycle_adder: N must be a multiple of W");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [N-1:0]    x_q, x_d;
    logic [N-1:0]    y_q, y_d;
    logic [N-1:0]    s_q, s_d;
    logic            carry_q, carry_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [W-1:0]    chunk_a, chunk_b, chunk_sum;
    logic            chunk_co;

    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < K; i++) begin
            if (idx_q == IW'(i)) begin
                chunk_a = x_q[i*W +: W];
                chunk_b = y_q[i*W +: W];
            end
        end
    end

    ripple_carry_adder #(.N(W)) u_chunk_adder (
        .a   (chunk_a),
        .b   (chunk_b),
        .ci  (carry_q),
        .sum (chunk_sum),
        .co  (chunk_co)
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        s_d         = s_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d        = x;
                    y_d        = y;
                    carry_d    = cin;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < K; i++) begin
                    if (idx_q == IW'(i)) begin
                        s_d[i*W +: W] = chunk_sum;
                    end
                end
                carry_d = chunk_co;
                // Stop on the last chunk rather than wrapping the index.
                if (idx_q == IW'(K - 1)) begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            s_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            s_q         <= s_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    // After the final chunk the carry register holds the true carry out of bit N-1.
    assign cout      = carry_q;

`ifdef MULTI_CYCLE_ADDER_OVF_EN
    assign ovf = (x_q[N-1] == y_q[N-1]) && (s_q[N-1] != x_q[N-1]);
`endif

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Scoreboard bench for multi_cycle_adder at N=64, W=16; ovf checked when MULTI_CYCLE_ADDER_OVF_EN is defined.
module tb_multi_cycle_adder;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] x = '0;
    logic [N-1:0] y = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] s;
    logic         cout;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
    logic         ovf;
`endif

    int vec_count = 0;
    int miss_count = 0;

    typedef struct {
        logic [N-1:0] s;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    multi_cycle_adder #(.N(64), .W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
`ifdef MULTI_CYCLE_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [N-1:0] es, input logic ec, input logic eo);
        exp_t e;
        e.s    = es;
        e.cout = ec;
        e.ovf  = eo;
        return e;
    endfunction

    // Golden for random vectors: full-width add plus the sign rule for overflow.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        logic [N:0] full;
        exp_t e;
        full   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
        e.s    = full[N-1:0];
        e.cout = full[N];
        e.ovf  = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                                 input exp_t e, input bit track);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            vec_count++;
            miss_count++;
            $display("[TB] FAIL accept_timeout: got in_ready=%0b, expected 1 within 50 cycles", in_ready);
            return;
        end
        x        = a;
        y        = b;
        cin      = c;
        in_valid = 1'b1;
        if (track) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
                vec_count++;
                miss_count++;
                $display("[TB] FAIL unexpected_result: got s=0x%0h, expected no result", s);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("sum", s, mon_e.s);
                checkOutput("cout", {{(N-1){1'b0}}, cout}, {{(N-1){1'b0}}, mon_e.cout});
`ifdef MULTI_CYCLE_ADDER_OVF_EN
                checkOutput("ovf", {{(N-1){1'b0}}, ovf}, {{(N-1){1'b0}}, mon_e.ovf});
`endif
            end
        end
    end

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            vec_count++;
            miss_count++;
            $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic         rc;
        int           waited;

        #2 rst = 1'b1;
        #1;
        checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_s", s, 64'd0);
        checkOutput("reset_cout", {63'd0, cout}, 64'd0);
`ifdef MULTI_CYCLE_ADDER_OVF_EN
        checkOutput("reset_ovf", {63'd0, ovf}, 64'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, mk(64'd0, 1'b1, 1'b0), 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("busy_in_ready", {63'd0, in_ready}, 64'd0);
            checkOutput("latency_out_valid", {63'd0, out_valid}, {63'd0, (i == 4)});
        end

        applyStimulus(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, mk(64'h0000_0000_0001_0000, 1'b0, 1'b0), 1'b1);
        applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                      mk(64'h2222_2222_2222_2211, 1'b0, 1'b0), 1'b1);
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1), 1'b1);
        applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, mk(64'd0, 1'b1, 1'b1), 1'b1);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                      mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0), 1'b1);
        drain();

        // Backpressure: result must hold while a competing request is offered.
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(64'd5, 64'd7, 1'b0, mk(64'd12, 1'b0, 1'b0), 1'b1);
        waited = 0;
        while (out_valid !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("bp_out_valid_rise", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            x        = 64'd99;
            y        = 64'd1;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("bp_s", s, 64'd12);
            checkOutput("bp_cout", {63'd0, cout}, 64'd0);
            checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        drain();

        // Abort after two chunks; nothing may be presented for this operation.
        applyStimulus(64'h0000_0000_0000_0ABC, 64'd1, 1'b0, mk(64'd0, 1'b0, 1'b0), 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("abort_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("abort_s", s, 64'd0);
        checkOutput("abort_cout", {63'd0, cout}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_quiet_out_valid", {63'd0, out_valid}, 64'd0);
        end
        applyStimulus(64'd1, 64'd2, 1'b0, mk(64'd3, 1'b0, 1'b0), 1'b1);
        drain();

        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rc, model(ra, rb, rc), 1'b1);
        end
        drain();

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
